// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard matrix controller:
// parser states, prefix bytes, ignored codes and matrix geometry.
package ps2_pkg;

  localparam int ROWS = 10;
  localparam int COLS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } ps2_state_e;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] SC_FAKE_RSHIFT = 8'h59;

  // Remaining Pause bytes after the leading E1
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } km_entry_t;

  // Keyboard status / ack bytes that never describe a key
  function automatic logic is_ignored(input logic [7:0] c);
    case (c)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_ignored = 1'b1;
      default:                                  is_ignored = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Registered 512-entry scancode ROM: {ext, code} -> {hit, row, col} of the
// 10x8 key matrix. Unmapped keys return hit=0.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic [8:0] key,
  output km_entry_t entry
);

  function automatic km_entry_t ent(input logic [3:0] r, input logic [2:0] c);
    ent = '{hit: 1'b1, row: r, col: c};
  endfunction

  km_entry_t lut_s;

  // Scancode to matrix position lookup
  always_comb begin
    lut_s = '{hit: 1'b0, row: 4'd0, col: 3'd0};
    case (key)
      9'h016: lut_s = ent(4'd0, 3'd0);  9'h01E: lut_s = ent(4'd0, 3'd1);  9'h026: lut_s = ent(4'd0, 3'd2);  9'h025: lut_s = ent(4'd0, 3'd3);
      9'h02E: lut_s = ent(4'd0, 3'd4);  9'h036: lut_s = ent(4'd0, 3'd5);  9'h03D: lut_s = ent(4'd0, 3'd6);  9'h03E: lut_s = ent(4'd0, 3'd7);
      9'h046: lut_s = ent(4'd1, 3'd0);  9'h045: lut_s = ent(4'd1, 3'd1);  9'h04E: lut_s = ent(4'd1, 3'd2);  9'h055: lut_s = ent(4'd1, 3'd3);
      9'h066: lut_s = ent(4'd1, 3'd4);  9'h05A: lut_s = ent(4'd1, 3'd5);  9'h076: lut_s = ent(4'd1, 3'd6);  9'h00D: lut_s = ent(4'd1, 3'd7);
      9'h015: lut_s = ent(4'd2, 3'd0);  9'h01D: lut_s = ent(4'd2, 3'd1);  9'h024: lut_s = ent(4'd2, 3'd2);  9'h02D: lut_s = ent(4'd2, 3'd3);
      9'h02C: lut_s = ent(4'd2, 3'd4);  9'h035: lut_s = ent(4'd2, 3'd5);  9'h03C: lut_s = ent(4'd2, 3'd6);  9'h043: lut_s = ent(4'd2, 3'd7);
      9'h044: lut_s = ent(4'd3, 3'd0);  9'h04D: lut_s = ent(4'd3, 3'd1);  9'h01C: lut_s = ent(4'd3, 3'd2);  9'h01B: lut_s = ent(4'd3, 3'd3);
      9'h023: lut_s = ent(4'd3, 3'd4);  9'h02B: lut_s = ent(4'd3, 3'd5);  9'h034: lut_s = ent(4'd3, 3'd6);  9'h033: lut_s = ent(4'd3, 3'd7);
      9'h03B: lut_s = ent(4'd4, 3'd0);  9'h042: lut_s = ent(4'd4, 3'd1);  9'h04B: lut_s = ent(4'd4, 3'd2);  9'h04C: lut_s = ent(4'd4, 3'd3);
      9'h01A: lut_s = ent(4'd4, 3'd4);  9'h022: lut_s = ent(4'd4, 3'd5);  9'h021: lut_s = ent(4'd4, 3'd6);  9'h02A: lut_s = ent(4'd4, 3'd7);
      9'h032: lut_s = ent(4'd5, 3'd0);  9'h031: lut_s = ent(4'd5, 3'd1);  9'h03A: lut_s = ent(4'd5, 3'd2);  9'h041: lut_s = ent(4'd5, 3'd3);
      9'h049: lut_s = ent(4'd5, 3'd4);  9'h04A: lut_s = ent(4'd5, 3'd5);  9'h029: lut_s = ent(4'd5, 3'd6);
      9'h012, 9'h059: lut_s = ent(4'd5, 3'd7);
      9'h014, 9'h114: lut_s = ent(4'd6, 3'd0);
      9'h011, 9'h111: lut_s = ent(4'd6, 3'd1);
      9'h058: lut_s = ent(4'd6, 3'd2);  9'h075: lut_s = ent(4'd6, 3'd3);  9'h072: lut_s = ent(4'd6, 3'd4);  9'h06B: lut_s = ent(4'd6, 3'd5);
      9'h074: lut_s = ent(4'd6, 3'd6);  9'h070: lut_s = ent(4'd6, 3'd7);
      9'h175: lut_s = ent(4'd7, 3'd0);  9'h172: lut_s = ent(4'd7, 3'd1);  9'h16B: lut_s = ent(4'd7, 3'd2);  9'h174: lut_s = ent(4'd7, 3'd3);
      9'h171: lut_s = ent(4'd7, 3'd4);  9'h170: lut_s = ent(4'd7, 3'd5);  9'h16C: lut_s = ent(4'd7, 3'd6);  9'h169: lut_s = ent(4'd7, 3'd7);
      9'h005: lut_s = ent(4'd8, 3'd0);  9'h006: lut_s = ent(4'd8, 3'd1);  9'h004: lut_s = ent(4'd8, 3'd2);  9'h00C: lut_s = ent(4'd8, 3'd3);
      9'h003: lut_s = ent(4'd8, 3'd4);  9'h00B: lut_s = ent(4'd8, 3'd5);  9'h083: lut_s = ent(4'd8, 3'd6);  9'h00A: lut_s = ent(4'd8, 3'd7);
      9'h001: lut_s = ent(4'd9, 3'd0);  9'h009: lut_s = ent(4'd9, 3'd1);  9'h078: lut_s = ent(4'd9, 3'd2);  9'h007: lut_s = ent(4'd9, 3'd3);
      9'h052: lut_s = ent(4'd9, 3'd4);  9'h054: lut_s = ent(4'd9, 3'd5);  9'h05B: lut_s = ent(4'd9, 3'd6);  9'h05D: lut_s = ent(4'd9, 3'd7);
      default: lut_s = '{hit: 1'b0, row: 4'd0, col: 3'd0};
    endcase
  end

  // ROM output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry <= '{hit: 1'b0, row: 4'd0, col: 3'd0};
    end else begin
      entry <= lut_s;
    end
  end

endmodule

// File: rtl/ps2_keyb_matrix.sv
// PS/2 byte stream to 10x8 Lynx key matrix: prefix parser, keymap pipeline,
// matrix state and row read. Define KEYB_RESET_EN to build Ctrl+Alt+Del detection.
module ps2_keyb_matrix
  import ps2_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic [7:0] code,
  input  logic [3:0] row,
  output logic [7:0] cols,
  output logic       resetReq
);

  ps2_state_e state_r, state_s;
  logic [2:0] skip_r, skip_s;
  logic       armed_r;
  logic       strb_s;
  logic       ev_valid_s, ev_make_s, ev_ext_s, bat_s;
  logic       ev_valid_r, ev_make_r, bat_r;
  km_entry_t  km_s;
  logic [ROWS-1:0][COLS-1:0] matrix_r;

  // A strobe coinciding with reset release is dropped until armed_r is set
  assign strb_s = strb & armed_r;

  // Prefix parser: next state and event decode
  always_comb begin
    state_s    = state_r;
    skip_s     = skip_r;
    ev_valid_s = 1'b0;
    ev_make_s  = 1'b0;
    ev_ext_s   = 1'b0;
    bat_s      = 1'b0;
    if (strb_s) begin
      case (state_r)
        ST_IDLE: begin
          if (code == SC_E0) begin
            state_s = ST_EXT;
          end else if (code == SC_F0) begin
            state_s = ST_BRK;
          end else if (code == SC_E1) begin
            state_s = ST_SKIP;
            skip_s  = SKIP_LEN;
          end else if (code == SC_AA) begin
            bat_s = 1'b1;
          end else if (is_ignored(code)) begin
            state_s = ST_IDLE;
          end else begin
            ev_valid_s = 1'b1;
            ev_make_s  = 1'b1;
          end
        end
        ST_EXT: begin
          if (code == SC_F0) begin
            state_s = ST_EXTBRK;
          end else if ((code == SC_FAKE_LSHIFT) || (code == SC_FAKE_RSHIFT)) begin
            state_s = ST_IDLE;
          end else begin
            state_s    = ST_IDLE;
            ev_valid_s = 1'b1;
            ev_make_s  = 1'b1;
            ev_ext_s   = 1'b1;
          end
        end
        ST_BRK: begin
          state_s    = ST_IDLE;
          ev_valid_s = 1'b1;
        end
        ST_EXTBRK: begin
          state_s    = ST_IDLE;
          ev_valid_s = 1'b1;
          ev_ext_s   = 1'b1;
        end
        ST_SKIP: begin
          if (skip_r <= 3'd1) begin
            state_s = ST_IDLE;
            skip_s  = 3'd0;
          end else begin
            skip_s = skip_r - 3'd1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          skip_s  = 3'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Parser state and first pipeline stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      skip_r     <= 3'd0;
      armed_r    <= 1'b0;
      ev_valid_r <= 1'b0;
      ev_make_r  <= 1'b0;
      bat_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      skip_r     <= skip_s;
      armed_r    <= 1'b1;
      ev_valid_r <= ev_valid_s;
      ev_make_r  <= ev_make_s;
      bat_r      <= bat_s;
    end
  end

  ps2_keymap u_keymap (
    .clock (clock),
    .reset (reset),
    .key   ({ev_ext_s, code}),
    .entry (km_s)
  );

  // Key matrix: BAT releases everything, otherwise a mapped event updates one bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      matrix_r <= '1;
    end else if (bat_r) begin
      matrix_r <= '1;
    end else if (ev_valid_r && km_s.hit && (km_s.row <= 4'd9)) begin
      matrix_r[km_s.row][km_s.col] <= ~ev_make_r;
    end
  end

  // Row-addressed column read; rows 10-15 read as released
  always_comb begin
    if (row <= 4'd9) begin
      cols = matrix_r[row];
    end else begin
      cols = 8'hFF;
    end
  end

`ifdef KEYB_RESET_EN
  logic ctrl_r, alt_r, del_r, rr_r;

  // Modifier flags follow make/break events directly from the parser
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_r <= 1'b0;
      alt_r  <= 1'b0;
      del_r  <= 1'b0;
    end else if (ev_valid_s) begin
      if (code == 8'h14) ctrl_r <= ev_make_s;
      if (code == 8'h11) alt_r  <= ev_make_s;
      if (ev_ext_s && (code == 8'h71)) del_r <= ev_make_s;
    end
  end

  // Registered Ctrl+Alt+Del request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_r <= 1'b0;
    end else begin
      rr_r <= ctrl_r & alt_r & del_r;
    end
  end

  assign resetReq = rr_r;
`else
  assign resetReq = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyb_matrix.sv
// Self-checking bench for ps2_keyb_matrix: vector table through a timed
// scoreboard, plus hand-written latency and reset corner sequences.
`timescale 1ns/1ps
module tb_ps2_keyb_matrix;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       strb  = 1'b0;
  logic [7:0] code  = 8'h00;
  logic [3:0] row   = 4'd0;
  logic [7:0] cols;
  logic       resetReq;

`ifdef KEYB_RESET_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  ps2_keyb_matrix dut (
    .clock    (clock),
    .reset    (reset),
    .strb     (strb),
    .code     (code),
    .row      (row),
    .cols     (cols),
    .resetReq (resetReq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       stb;
    logic [7:0] code;
    logic [3:0] row;
    logic [7:0] exp_cols;
    logic       exp_rr;
  } vec_t;

  typedef struct {
    int         due;
    logic       is_rr;
    logic [7:0] exp;
    string      name;
  } sb_t;

  vec_t tv[$];
  sb_t  sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: compare entries when their due cycle arrives
  always @(negedge clock) begin
    sb_t        e;
    logic [7:0] act;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e   = sbq.pop_front();
      act = e.is_rr ? {7'd0, resetReq} : cols;
      checks++;
      if (e.due != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s (due %0d, at %0d): got %h expected %h", e.name, e.due, cyc, act, e.exp);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic [7:0] c, input logic [3:0] r,
                     input logic [7:0] ec, input logic er);
    vec_t v;
    v.stb = s; v.code = c; v.row = r; v.exp_cols = ec; v.exp_rr = er;
    tv.push_back(v);
  endtask

  task automatic pulse(input logic [7:0] c);
    @(posedge clock); #1;
    strb = 1'b1; code = c;
    @(posedge clock); #1;
    strb = 1'b0;
  endtask

  initial begin
    // A press/release, rows 3
    add(1'b1, 8'h1C, 4'd3, 8'hFB, 1'b0);
    add(1'b1, 8'hF0, 4'd3, 8'hFB, 1'b0);
    add(1'b1, 8'h1C, 4'd3, 8'hFF, 1'b0);
    // cursor up vs keypad 8
    add(1'b1, 8'hE0, 4'd7, 8'hFF, 1'b0);
    add(1'b1, 8'h75, 4'd7, 8'hFE, 1'b0);
    add(1'b1, 8'h75, 4'd6, 8'hF7, 1'b0);
    add(1'b0, 8'h00, 4'd7, 8'hFE, 1'b0);
    add(1'b1, 8'hE0, 4'd7, 8'hFE, 1'b0);
    add(1'b1, 8'hF0, 4'd7, 8'hFE, 1'b0);
    add(1'b1, 8'h75, 4'd7, 8'hFF, 1'b0);
    add(1'b0, 8'h00, 4'd6, 8'hF7, 1'b0);
    add(1'b1, 8'hF0, 4'd6, 8'hF7, 1'b0);
    add(1'b1, 8'h75, 4'd6, 8'hFF, 1'b0);
    // Pause sequence is discarded (14 would otherwise be Ctrl on row 6)
    add(1'b1, 8'hE1, 4'd6, 8'hFF, 1'b0);
    add(1'b1, 8'h14, 4'd6, 8'hFF, 1'b0);
    add(1'b1, 8'h77, 4'd6, 8'hFF, 1'b0);
    add(1'b1, 8'hE1, 4'd6, 8'hFF, 1'b0);
    add(1'b1, 8'hF0, 4'd6, 8'hFF, 1'b0);
    add(1'b1, 8'h14, 4'd6, 8'hFF, 1'b0);
    add(1'b1, 8'hF0, 4'd6, 8'hFF, 1'b0);
    add(1'b1, 8'h77, 4'd6, 8'hFF, 1'b0);
    add(1'b1, 8'h1C, 4'd3, 8'hFB, 1'b0);
    // both Shifts share a bit, then BAT clears everything
    add(1'b1, 8'h12, 4'd5, 8'h7F, 1'b0);
    add(1'b1, 8'h59, 4'd5, 8'h7F, 1'b0);
    add(1'b1, 8'hAA, 4'd5, 8'hFF, 1'b0);
    add(1'b0, 8'h00, 4'd3, 8'hFF, 1'b0);
    // ignored ack byte, fake shift, out-of-range row
    add(1'b1, 8'hFA, 4'd3, 8'hFF, 1'b0);
    add(1'b1, 8'hE0, 4'd5, 8'hFF, 1'b0);
    add(1'b1, 8'h12, 4'd5, 8'hFF, 1'b0);
    add(1'b0, 8'h00, 4'd15, 8'hFF, 1'b0);
    // Ctrl + Alt + Del
    add(1'b1, 8'h14, 4'd6, 8'hFE, 1'b0);
    add(1'b1, 8'h11, 4'd6, 8'hFC, 1'b0);
    add(1'b1, 8'hE0, 4'd7, 8'hFF, 1'b0);
    add(1'b1, 8'h71, 4'd7, 8'hEF, RR_EN);
    add(1'b1, 8'hE0, 4'd7, 8'hEF, RR_EN);
    add(1'b1, 8'hF0, 4'd7, 8'hEF, RR_EN);
    add(1'b1, 8'h71, 4'd7, 8'hFF, 1'b0);
    add(1'b1, 8'hF0, 4'd6, 8'hFC, 1'b0);
    add(1'b1, 8'h14, 4'd6, 8'hFD, 1'b0);
    add(1'b1, 8'hF0, 4'd6, 8'hFD, 1'b0);
    add(1'b1, 8'h11, 4'd6, 8'hFF, 1'b0);

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int r = 0; r < 10; r++) begin
      row = 4'(r); #1;
      check($sformatf("reset_row%0d", r), cols, 8'hFF);
    end
    row = 4'd12; #1;
    check("reset_row12", cols, 8'hFF);
    check("reset_resetReq", {7'd0, resetReq}, 8'h00);

    // table through the scoreboard
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clock); #1;
      row = tv[i].row; strb = tv[i].stb; code = tv[i].code;
      sbq.push_back('{due: cyc + 2, is_rr: 1'b0, exp: tv[i].exp_cols, name: $sformatf("cols_v%0d", i)});
      sbq.push_back('{due: cyc + 3, is_rr: 1'b1, exp: {7'd0, tv[i].exp_rr}, name: $sformatf("resetReq_v%0d", i)});
      @(posedge clock); #1;
      strb = 1'b0;
      repeat (2) @(posedge clock);
    end
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clock);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end

    // exact two-cycle latency
    row = 4'd3;
    @(posedge clock); #1;
    strb = 1'b1; code = 8'h1C;
    @(posedge clock); #1;
    strb = 1'b0;
    check("latency_n1", cols, 8'hFF);
    @(posedge clock); #1;
    check("latency_n2", cols, 8'hFB);

    // reset while in EXTBRK with Ctrl+Alt+Del held
    pulse(8'h14); pulse(8'h11); pulse(8'hE0); pulse(8'h71);
    pulse(8'hE0); pulse(8'hF0);
    repeat (2) @(posedge clock); #1;
    check("pre_reset_rr", {7'd0, resetReq}, {7'd0, RR_EN});
    @(negedge clock);
    reset = 1'b0; #1;
    check("async_reset_cols", cols, 8'hFF);
    check("async_reset_rr", {7'd0, resetReq}, 8'h00);
    // strobe present on the cycle reset releases is dropped
    @(negedge clock);
    strb = 1'b1; code = 8'h1C; #1;
    reset = 1'b1;
    @(posedge clock); #1;
    strb = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("strb_at_release", cols, 8'hFF);
    // parser back in IDLE: plain 75 is keypad 8, not cursor-up break
    pulse(8'h75);
    @(posedge clock); #1;
    row = 4'd6; #1;
    check("post_reset_make", cols, 8'hF7);
    pulse(8'hF0); pulse(8'h75);

    // reset in SKIP clears the skip counter
    pulse(8'hE1); pulse(8'h14);
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock);
    row = 4'd3;
    pulse(8'h1C);
    @(posedge clock); #1;
    check("skip_reset_make", cols, 8'hFB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
